// File: rtl/dct_pkg.sv
// Shared types and sizes for the DCT block sequencer and its drain buffer.
package dct_pkg;

    localparam int unsigned DCT_N     = 64;
    localparam int unsigned DCT_IN_W  = 9;
    localparam int unsigned DCT_OUT_W = 27;

    typedef logic signed [DCT_IN_W-1:0]  dct_pix_t;
    typedef logic signed [DCT_OUT_W-1:0] dct_coef_t;

    typedef enum logic [1:0] {
        FILL,
        START,
        WAIT
    } seq_state_t;

endpackage

// File: rtl/dct_block_sequencer_if.sv
// Pixel input stream and coefficient output stream of the DCT block sequencer.
// master = pixel source / coefficient consumer, slave = sequencer.
interface dct_block_sequencer_if #(
    parameter int unsigned IN_W  = dct_pkg::DCT_IN_W,
    parameter int unsigned OUT_W = dct_pkg::DCT_OUT_W
);

    logic                    pix_valid;
    logic signed [IN_W-1:0]  pix_data;
    logic                    pix_ready;

    logic                    coef_valid;
    logic signed [OUT_W-1:0] coef_data;
    logic [5:0]              coef_index;
    logic                    coef_last;
    logic                    coef_ready;

    modport master (
        output pix_valid, pix_data, coef_ready,
        input  pix_ready, coef_valid, coef_data, coef_index, coef_last
    );

    modport slave (
        input  pix_valid, pix_data, coef_ready,
        output pix_ready, coef_valid, coef_data, coef_index, coef_last
    );

endinterface

// File: rtl/dct_coef_drain.sv
// Output buffer: captures a full coefficient block on load and streams it out
// one element per valid/ready handshake, independently of the fill side.
module dct_coef_drain
    import dct_pkg::*;
#(
    parameter int unsigned OUT_W = DCT_OUT_W
) (
    input  logic                     clock,
    input  logic                     rst_,
    input  logic                     load,
    input  logic [DCT_N*OUT_W-1:0]   load_data,
    input  logic                     coef_ready,
    output logic                     coef_valid,
    output logic signed [OUT_W-1:0]  coef_data,
    output logic [5:0]               coef_index,
    output logic                     coef_last,
    output logic                     out_full,
    output logic [15:0]              blocks_done
);

    logic signed [OUT_W-1:0] out_buf_q [DCT_N];
    logic [5:0]              rd_idx_q;
    logic                    out_full_q;
    logic [15:0]             blocks_done_q;
    logic                    handshake;

    assign handshake = out_full_q & coef_ready;

    // Load a whole block, or advance the read pointer on each accepted beat.
    always_ff @(posedge clock or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < DCT_N; i++) out_buf_q[i] <= '0;
            rd_idx_q      <= '0;
            out_full_q    <= 1'b0;
            blocks_done_q <= '0;
        end else if (load) begin
            for (int i = 0; i < DCT_N; i++) out_buf_q[i] <= load_data[i*OUT_W +: OUT_W];
            rd_idx_q   <= '0;
            out_full_q <= 1'b1;
        end else if (handshake) begin
            // 6-bit pointer wraps 63 -> 0 on its own
            rd_idx_q <= rd_idx_q + 6'd1;
            if (rd_idx_q == 6'd63) begin
                out_full_q    <= 1'b0;
                blocks_done_q <= blocks_done_q + 16'd1;
            end
        end
    end

    // Presented beat is a pure function of the buffer state, so it holds under stall.
    always_comb begin
        coef_valid  = out_full_q;
        coef_data   = out_buf_q[rd_idx_q];
        coef_index  = rd_idx_q;
        coef_last   = out_full_q & (rd_idx_q == 6'd63);
        out_full    = out_full_q;
        blocks_done = blocks_done_q;
    end

endmodule

// File: rtl/dct_block_sequencer.sv
// Gathers 64 pixels, kicks the TwoDDCT core, captures its result into the
// drain buffer and abandons the block if the core never answers.
module dct_block_sequencer
    import dct_pkg::*;
#(
    parameter int unsigned IN_W    = DCT_IN_W,
    parameter int unsigned OUT_W   = DCT_OUT_W,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    clock,
    input  logic                    rst_,
    dct_block_sequencer_if.slave    stream,
    output logic [DCT_N*IN_W-1:0]   dct_x,
    output logic                    dct_start,
    input  logic [DCT_N*OUT_W-1:0]  dct_y,
    input  logic                    dct_xfc,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [15:0]             blocks_done
);

    localparam int unsigned          WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    seq_state_t             state_q, state_d;
    logic [6:0]             in_cnt_q, in_cnt_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                   timeout_err_q, timeout_err_d;
    logic signed [IN_W-1:0] in_buf_q [DCT_N];
    logic                   accept;
    logic                   load;
    logic                   out_full;

    logic                    coef_valid;
    logic signed [OUT_W-1:0] coef_data;
    logic [5:0]              coef_index;
    logic                    coef_last;

    assign stream.pix_ready = (state_q == FILL) && (in_cnt_q < 7'd64);
    assign accept           = stream.pix_valid & stream.pix_ready;
    // Only a WAIT-state xfc belongs to the block we launched.
    assign load             = (state_q == WAIT) & dct_xfc;
    assign busy             = (state_q != FILL) | (in_cnt_q != 7'd0) | out_full;
    assign timeout_err      = timeout_err_q;

    // Core input is wired straight from the buffer so it stays put through START/WAIT.
    for (genvar g = 0; g < DCT_N; g++) begin : g_dct_x
        assign dct_x[g*IN_W +: IN_W] = in_buf_q[g];
    end

    // Input buffer: accepted pixel lands at the current fill position.
    always_ff @(posedge clock or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < DCT_N; i++) in_buf_q[i] <= '0;
        end else if (accept) begin
            in_buf_q[in_cnt_q[5:0]] <= stream.pix_data;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clock or negedge rst_) begin
        if (!rst_) begin
            state_q       <= FILL;
            in_cnt_q      <= '0;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_cnt_q      <= in_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic; leaves FILL on the cycle the 64th pixel is taken so
    // dct_start follows the last accept by one cycle.
    always_comb begin
        state_d       = state_q;
        in_cnt_d      = in_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        dct_start     = 1'b0;
        if (accept) in_cnt_d = in_cnt_q + 7'd1;
        unique case (state_q)
            FILL: begin
                if (in_cnt_d == 7'd64 && !out_full) state_d = START;
            end
            START: begin
                dct_start  = 1'b1;
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (load) begin
                    in_cnt_d = '0;
                    state_d  = FILL;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Core gave up on us: drop the block and flag it for good.
                    timeout_err_d = 1'b1;
                    in_cnt_d      = '0;
                    state_d       = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    dct_coef_drain #(
        .OUT_W (OUT_W)
    ) u_drain (
        .clock       (clock),
        .rst_        (rst_),
        .load        (load),
        .load_data   (dct_y),
        .coef_ready  (stream.coef_ready),
        .coef_valid  (coef_valid),
        .coef_data   (coef_data),
        .coef_index  (coef_index),
        .coef_last   (coef_last),
        .out_full    (out_full),
        .blocks_done (blocks_done)
    );

    assign stream.coef_valid = coef_valid;
    assign stream.coef_data  = coef_data;
    assign stream.coef_index = coef_index;
    assign stream.coef_last  = coef_last;

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Bench for dct_block_sequencer: core stub (y = 2*x, configurable xfc latency),
// pixel driver, random backpressure and a scoreboard fed from the pixels sent.
module tb_dct_block_sequencer;
    import dct_pkg::*;

    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        dct_coef_t  data;
        logic [5:0] index;
        logic       last;
    } beat_t;

    logic                         clock = 1'b0;
    logic                         rst_  = 1'b0;
    logic [DCT_N*DCT_IN_W-1:0]    dct_x;
    logic                         dct_start;
    logic [DCT_N*DCT_OUT_W-1:0]   dct_y = '0;
    logic                         dct_xfc = 1'b0;
    logic                         busy;
    logic                         timeout_err;
    logic [15:0]                  blocks_done;

    dct_block_sequencer_if #(.IN_W(DCT_IN_W), .OUT_W(DCT_OUT_W)) stream ();

    dct_block_sequencer #(
        .IN_W    (DCT_IN_W),
        .OUT_W   (DCT_OUT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .rst_        (rst_),
        .stream      (stream),
        .dct_x       (dct_x),
        .dct_start   (dct_start),
        .dct_y       (dct_y),
        .dct_xfc     (dct_xfc),
        .busy        (busy),
        .timeout_err (timeout_err),
        .blocks_done (blocks_done)
    );

    always #5 clock = ~clock;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    beat_t sb_q[$];
    int    starts = 0;
    int    last_start_cyc = -1;
    int    last_accept_cyc = -1;
    int    first_valid_cyc = -1;
    int    beats = 0;
    int    xfc_lat = 5;      // 0: core never answers
    int    ready_mode = 0;   // 0: always ready, 1: ready 1 of 3, 2: stalled
    bit    pending = 1'b0;
    int    fire_at = 0;
    int    stub_v;
    logic [DCT_N*DCT_OUT_W-1:0] y_hold = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clock) cyc++;

    // Core stub: latch x on dct_start, present y = 2*x after xfc_lat cycles.
    always @(negedge clock) begin
        if (rst_ && dct_start) begin
            starts++;
            last_start_cyc = cyc;
            for (int i = 0; i < DCT_N; i++) begin
                stub_v = dct_pix_t'(dct_x[i*DCT_IN_W +: DCT_IN_W]);
                y_hold[i*DCT_OUT_W +: DCT_OUT_W] = DCT_OUT_W'(stub_v * 2);
            end
            if (xfc_lat != 0) begin
                pending = 1'b1;
                fire_at = cyc + xfc_lat;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (pending && cyc == fire_at) begin
            dct_xfc = 1'b1;
            dct_y   = y_hold;
            pending = 1'b0;
        end else begin
            dct_xfc = 1'b0;
        end
        case (ready_mode)
            0:       stream.coef_ready = 1'b1;
            1:       stream.coef_ready = ($urandom_range(0, 2) == 0);
            default: stream.coef_ready = 1'b0;
        endcase
    end

    // Monitor: pops expected beats on handshake, checks hold-under-stall.
    logic             prev_hold = 1'b0;
    logic             was_valid = 1'b0;
    logic [63:0]      prev_data;
    logic [5:0]       prev_index;
    always @(negedge clock) begin
        beat_t e;
        if (!rst_) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", stream.coef_valid, 1);
                check("hold_data", stream.coef_data, prev_data);
                check("hold_index", stream.coef_index, prev_index);
            end
            if (stream.coef_valid && !was_valid) first_valid_cyc = cyc;
            if (stream.coef_valid && stream.coef_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got index %0d data %0d, required no beat",
                             stream.coef_index, stream.coef_data);
                end else begin
                    e = sb_q.pop_front();
                    check("coef_data", stream.coef_data, e.data);
                    check("coef_index", stream.coef_index, e.index);
                    check("coef_last", stream.coef_last, e.last);
                end
                beats++;
            end
            prev_hold  = stream.coef_valid && !stream.coef_ready;
            prev_data  = stream.coef_data;
            prev_index = stream.coef_index;
        end
        was_valid = rst_ ? stream.coef_valid : 1'b0;
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic send_pixel(input dct_pix_t p);
        int n = 0;
        stream.pix_valid = 1'b1;
        stream.pix_data  = p;
        @(negedge clock);
        while (!stream.pix_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (!stream.pix_ready) check("pix_accept_bound", stream.pix_ready, 1);
        last_accept_cyc = cyc;
        @(posedge clock);
        #1;
        stream.pix_valid = 1'b0;
    endtask

    // Reference model: a delivered block is 2*pixel per element, index order.
    task automatic send_block(input dct_pix_t blk [DCT_N], input bit expect_out);
        beat_t e;
        int    v;
        if (expect_out) begin
            for (int i = 0; i < DCT_N; i++) begin
                v       = blk[i];
                e.data  = dct_coef_t'(v * 2);
                e.index = 6'(i);
                e.last  = (i == DCT_N - 1);
                sb_q.push_back(e);
            end
        end
        for (int i = 0; i < DCT_N; i++) send_pixel(blk[i]);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || stream.coef_valid) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check(name, sb_q.size(), 0);
    endtask

    task automatic wait_start(input int base, input string name);
        int n = 0;
        while (starts == base && n < 100) begin
            @(negedge clock);
            n++;
        end
        check(name, (starts > base), 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pix_ready"}, stream.pix_ready, 1);
        check({tag, "_coef_valid"}, stream.coef_valid, 0);
        check({tag, "_coef_last"}, stream.coef_last, 0);
        check({tag, "_dct_start"}, dct_start, 0);
        check({tag, "_dct_x_zero"}, (dct_x == '0), 1);
        check({tag, "_coef_index"}, stream.coef_index, 0);
        check({tag, "_coef_data"}, stream.coef_data, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_blocks_done"}, blocks_done, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required end of test");
        $fatal(1, "time limit reached");
    end

    initial begin
        dct_pix_t blk [DCT_N];
        int       base;
        int       acc;
        int       n;
        int       b0;

        stream.pix_valid = 1'b0;
        stream.pix_data  = '0;
        repeat (3) @(negedge clock);
        check_reset("por");
        @(posedge clock);
        #3 rst_ = 1'b1;
        sync();

        // Basic ramp 0..63, always ready.
        for (int i = 0; i < DCT_N; i++) blk[i] = dct_pix_t'(i);
        base = starts;
        send_block(blk, 1'b1);
        acc = last_accept_cyc;
        wait_start(base, "basic_start_seen");
        check("basic_start_latency", last_start_cyc - acc, 1);
        wait_drain("basic_drain");
        check("basic_valid_latency", first_valid_cyc - last_start_cyc, 6);
        check("basic_one_start", starts - base, 1);
        check("basic_blocks_done", blocks_done, 1);
        check("basic_idle", busy, 0);

        // Most negative samples under random backpressure.
        sync();
        ready_mode = 1;
        for (int i = 0; i < DCT_N; i++) blk[i] = -9'sd256;
        send_block(blk, 1'b1);
        wait_drain("neg_drain");
        check("neg_blocks_done", blocks_done, 2);

        // Two random blocks back-to-back, still random backpressure.
        sync();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DCT_N; i++) blk[i] = dct_pix_t'($urandom);
            send_block(blk, 1'b1);
        end
        wait_drain("rand_drain");
        check("rand_blocks_done", blocks_done, 4);

        // Overlap: block B fills while A is stuck in the drain buffer.
        sync();
        ready_mode = 2;
        base = starts;
        for (int i = 0; i < DCT_N; i++) blk[i] = 9'sd5;
        send_block(blk, 1'b1);
        wait_start(base, "ovl_start_a");
        n = 0;
        while (!stream.coef_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("ovl_a_valid", stream.coef_valid, 1);
        sync();
        for (int i = 0; i < DCT_N; i++) blk[i] = 9'sd7;
        send_block(blk, 1'b1);
        repeat (20) @(negedge clock);
        check("ovl_pix_ready_low", stream.pix_ready, 0);
        check("ovl_no_second_start", starts - base, 1);
        check("ovl_busy", busy, 1);
        ready_mode = 0;
        wait_drain("ovl_drain");
        check("ovl_two_starts", starts - base, 2);
        check("ovl_blocks_done", blocks_done, 6);

        // xfc lands on the timeout cycle: capture wins, no error.
        sync();
        xfc_lat = TIMEOUT;
        for (int i = 0; i < DCT_N; i++) blk[i] = dct_pix_t'($urandom);
        send_block(blk, 1'b1);
        wait_drain("race_drain");
        check("race_valid_latency", first_valid_cyc - last_start_cyc, TIMEOUT + 1);
        check("race_no_err", timeout_err, 0);
        check("race_blocks_done", blocks_done, 7);

        // Core never answers: block dropped, sticky error.
        sync();
        xfc_lat = 0;
        base = starts;
        for (int i = 0; i < DCT_N; i++) blk[i] = dct_pix_t'($urandom);
        send_block(blk, 1'b0);
        wait_start(base, "to_start_seen");
        n = 0;
        while (!timeout_err && n < 60) begin
            @(negedge clock);
            n++;
        end
        check("to_err_set", timeout_err, 1);
        check("to_err_latency", cyc - last_start_cyc, TIMEOUT + 1);
        check("to_pix_ready", stream.pix_ready, 1);
        check("to_no_valid", stream.coef_valid, 0);
        check("to_idle", busy, 0);
        repeat (10) @(negedge clock);
        sync();
        xfc_lat = 5;
        for (int i = 0; i < DCT_N; i++) blk[i] = dct_pix_t'($urandom);
        send_block(blk, 1'b1);
        wait_drain("to_next_drain");
        check("to_err_sticky", timeout_err, 1);
        check("to_blocks_done", blocks_done, 8);

        // Reset in the middle of a fill.
        sync();
        for (int i = 0; i < 30; i++) send_pixel(dct_pix_t'($urandom));
        #3 rst_ = 1'b0;
        #1 check_reset("rst_fill");
        @(posedge clock);
        #3 rst_ = 1'b1;
        sync();

        // Reset in the middle of a drain.
        ready_mode = 1;
        for (int i = 0; i < DCT_N; i++) blk[i] = dct_pix_t'($urandom);
        b0 = beats;
        send_block(blk, 1'b1);
        n = 0;
        while (beats < b0 + 10 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("rst_drain_progress", (beats >= b0 + 10), 1);
        sync();
        #2 rst_ = 1'b0;
        sb_q.delete();
        #1 check_reset("rst_drain");
        @(posedge clock);
        #3 rst_ = 1'b1;
        sync();

        // Fresh block after reset yields exactly 64 correct beats.
        ready_mode = 0;
        b0 = beats;
        for (int i = 0; i < DCT_N; i++) blk[i] = dct_pix_t'($urandom);
        send_block(blk, 1'b1);
        wait_drain("post_rst_drain");
        repeat (10) @(negedge clock);
        check("post_rst_beats", beats - b0, 64);
        check("post_rst_blocks_done", blocks_done, 1);
        check("post_rst_no_err", timeout_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
